me_search_sched: RTL and testbench

- Scheduler that shares one 4x4 SAD engine between NREQ motion-estimation requesters.
- Grants one requester at a time using round-robin arbitration.
- For the granted requester, issues the 25 candidate displacements (u,v in -2..+2) to the engine and tracks the minimum-SAD candidate.
- Returns the winning vector serially (x, then y) with the requester id; the SAD datapath and the pixel muxing live outside this block.

---
 rtl/me_search_sched_if.sv | 31 +++
 rtl/me_search_sched.sv | 216 +++++++++++++++++++++
 tb/tb_me_search_sched.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/me_search_sched_if.sv
// Handshake bundle between the ME search scheduler, its requesters and the shared SAD engine.
// The master modport is the scheduler side; the slave modport is the requester/engine side.
interface me_search_sched_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned SADW = 15,
  parameter int unsigned IDW  = 2
);
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  sel_id;
  logic            busy;
  logic            cand_valid;
  logic            cand_ready;
  logic [2:0]      cand_u;
  logic [2:0]      cand_v;
  logic            sad_valid;
  logic [SADW-1:0] sad_value;
  logic            out_valid;
  logic [2:0]      out_vector;
  logic [IDW-1:0]  out_id;

  modport master (
    input  req, cand_ready, sad_valid, sad_value,
    output gnt, sel_id, busy, cand_valid, cand_u, cand_v, out_valid, out_vector, out_id
  );

  modport slave (
    output req, cand_ready, sad_valid, sad_value,
    input  gnt, sel_id, busy, cand_valid, cand_u, cand_v, out_valid, out_vector, out_id
  );
endinterface

// File: rtl/me_search_sched.sv
// Round-robin scheduler sharing one 4x4 SAD engine: issues the 25 (u,v) candidates of a
// +-2 window for the granted requester, tracks the minimum SAD and returns the vector serially.
module me_search_sched #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned SADW = 15,
  parameter int unsigned IDW  = 2
) (
  input logic             clk,
  input logic             rst_n,
  me_search_sched_if.master bus
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StGrant = 3'd1;
  localparam logic [2:0] StIssue = 3'd2;
  localparam logic [2:0] StDrain = 3'd3;
  localparam logic [2:0] StOutX  = 3'd4;
  localparam logic [2:0] StOutY  = 3'd5;

  localparam logic [4:0] NumCand = 5'd25;
  localparam logic [2:0] UMin    = 3'b110;  // -2
  localparam logic [2:0] UMax    = 3'b010;  // +2
  localparam logic [2:0] VMax    = 3'b010;  // +2

  logic [2:0]      state_q, state_d;
  logic [IDW-1:0]  sel_id_q, sel_id_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            busy_q, busy_d;
  logic            cand_valid_q, cand_valid_d;
  logic [2:0]      cand_u_q, cand_u_d;
  logic [2:0]      cand_v_q, cand_v_d;
  logic            out_valid_q, out_valid_d;
  logic [2:0]      out_vector_q, out_vector_d;
  logic [IDW-1:0]  out_id_q, out_id_d;
  logic [IDW-1:0]  rr_q, rr_d;
  logic [SADW-1:0] min_q, min_d;
  logic [2:0]      best_u_q, best_u_d;
  logic [2:0]      best_v_q, best_v_d;
  logic [4:0]      issue_cnt_q, issue_cnt_d;
  logic [4:0]      res_cnt_q, res_cnt_d;
  logic [2:0]      res_u_q, res_u_d;
  logic [2:0]      res_v_q, res_v_d;

  logic            found;
  logic [IDW-1:0]  pick;
  int unsigned     idx;
  logic            enter_outx;

  // Raster scan: u runs -2..+2, then v steps down from +2 to -2.
  function automatic logic [5:0] scan_next(input logic [2:0] u, input logic [2:0] v);
    if (u == UMax) begin
      return {UMin, v - 3'd1};
    end
    return {u + 3'd1, v};
  endfunction

  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = (32'(rr_q) + i) % NREQ;
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        pick  = IDW'(idx);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    sel_id_d     = sel_id_q;
    gnt_d        = '0;
    busy_d       = busy_q;
    cand_valid_d = cand_valid_q;
    cand_u_d     = cand_u_q;
    cand_v_d     = cand_v_q;
    out_valid_d  = out_valid_q;
    out_vector_d = out_vector_q;
    out_id_d     = out_id_q;
    rr_d         = rr_q;
    min_d        = min_q;
    best_u_d     = best_u_q;
    best_v_d     = best_v_q;
    issue_cnt_d  = issue_cnt_q;
    res_cnt_d    = res_cnt_q;
    res_u_d      = res_u_q;
    res_v_d      = res_v_q;
    enter_outx   = 1'b0;

    // Results arrive in issue order, so a second scan counter names each one.
    if ((state_q == StIssue || state_q == StDrain) && bus.sad_valid && res_cnt_q < NumCand) begin
      res_cnt_d          = res_cnt_q + 5'd1;
      {res_u_d, res_v_d} = scan_next(res_u_q, res_v_q);
      if (res_cnt_q == 5'd0 || bus.sad_value < min_q) begin
        min_d    = bus.sad_value;
        best_u_d = res_u_q;
        best_v_d = res_v_q;
      end
    end

    case (state_q)
      StIdle: begin
        if (found) begin
          sel_id_d = pick;
          gnt_d    = NREQ'(1) << pick;
          busy_d   = 1'b1;
          state_d  = StGrant;
        end
      end
      StGrant: begin
        cand_u_d     = UMin;
        cand_v_d     = VMax;
        res_u_d      = UMin;
        res_v_d      = VMax;
        issue_cnt_d  = '0;
        res_cnt_d    = '0;
        min_d        = '1;
        cand_valid_d = 1'b1;
        state_d      = StIssue;
      end
      StIssue: begin
        if (cand_valid_q && bus.cand_ready) begin
          issue_cnt_d = issue_cnt_q + 5'd1;
          if (issue_cnt_q == NumCand - 5'd1) begin
            cand_valid_d = 1'b0;
            if (res_cnt_d == NumCand) begin
              enter_outx = 1'b1;
            end else begin
              state_d = StDrain;
            end
          end else begin
            {cand_u_d, cand_v_d} = scan_next(cand_u_q, cand_v_q);
          end
        end
      end
      StDrain: begin
        if (res_cnt_d == NumCand) begin
          enter_outx = 1'b1;
        end
      end
      StOutX: begin
        out_vector_d = best_v_q;
        state_d      = StOutY;
      end
      StOutY: begin
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
        rr_d        = (32'(sel_id_q) + 1 == NREQ) ? '0 : sel_id_q + 1'b1;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // best_u_d already folds in a result landing on this same cycle.
    if (enter_outx) begin
      out_valid_d  = 1'b1;
      out_vector_d = best_u_d;
      out_id_d     = sel_id_q;
      state_d      = StOutX;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      sel_id_q     <= '0;
      gnt_q        <= '0;
      busy_q       <= 1'b0;
      cand_valid_q <= 1'b0;
      cand_u_q     <= UMin;
      cand_v_q     <= VMax;
      out_valid_q  <= 1'b0;
      out_vector_q <= '0;
      out_id_q     <= '0;
      rr_q         <= '0;
      min_q        <= '1;
      best_u_q     <= UMin;
      best_v_q     <= VMax;
      issue_cnt_q  <= '0;
      res_cnt_q    <= '0;
      res_u_q      <= UMin;
      res_v_q      <= VMax;
    end else begin
      state_q      <= state_d;
      sel_id_q     <= sel_id_d;
      gnt_q        <= gnt_d;
      busy_q       <= busy_d;
      cand_valid_q <= cand_valid_d;
      cand_u_q     <= cand_u_d;
      cand_v_q     <= cand_v_d;
      out_valid_q  <= out_valid_d;
      out_vector_q <= out_vector_d;
      out_id_q     <= out_id_d;
      rr_q         <= rr_d;
      min_q        <= min_d;
      best_u_q     <= best_u_d;
      best_v_q     <= best_v_d;
      issue_cnt_q  <= issue_cnt_d;
      res_cnt_q    <= res_cnt_d;
      res_u_q      <= res_u_d;
      res_v_q      <= res_v_d;
    end
  end

  assign bus.gnt        = gnt_q;
  assign bus.sel_id     = sel_id_q;
  assign bus.busy       = busy_q;
  assign bus.cand_valid = cand_valid_q;
  assign bus.cand_u     = cand_u_q;
  assign bus.cand_v     = cand_v_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_vector = out_vector_q;
  assign bus.out_id     = out_id_q;

endmodule

// File: tb/tb_me_search_sched.sv
// Scoreboard bench for me_search_sched: an engine model answers candidates from a SAD table,
// a reference model predicts the winning vector and a monitor checks each serial result.
module tb_me_search_sched;
  localparam int unsigned NREQ = 4;
  localparam int unsigned SADW = 15;
  localparam int unsigned IDW  = 2;

  typedef struct {
    int id;
    int x;
    int y;
  } exp_t;

  typedef struct {
    int          due;
    int unsigned sad;
  } pend_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  me_search_sched_if #(.NREQ(NREQ), .SADW(SADW), .IDW(IDW)) bus ();

  me_search_sched #(.NREQ(NREQ), .SADW(SADW), .IDW(IDW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;
  int unsigned sad_tab[25];
  exp_t        exp_q[$];
  pend_t       pend[$];
  int          cyc        = 0;
  int          scan_k     = 0;
  int          res_sent   = 0;
  int          done_cnt   = 0;
  int          rr_ptr     = 0;
  int          ready_mode = 0;
  int          lat        = 1;
  int          rphase     = 0;
  bit          spur_en    = 1'b0;
  bit          stalled_prev = 1'b0;
  logic [2:0]  held_u, held_v;
  logic        prev_busy = 1'b0;
  logic [NREQ-1:0] prev_gnt = '0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic finish_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  task automatic check_reset();
    chk("rst_gnt", bus.gnt, 0);
    chk("rst_sel_id", bus.sel_id, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_cand_valid", bus.cand_valid, 0);
    chk("rst_cand_u", $signed(bus.cand_u), -2);
    chk("rst_cand_v", $signed(bus.cand_v), 2);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_vector", bus.out_vector, 0);
    chk("rst_out_id", bus.out_id, 0);
  endtask

  // Table index k follows scan order: k = (2 - v) * 5 + (u + 2).
  task automatic fill_table(input int mode);
    for (int k = 0; k < 25; k++) begin
      case (mode)
        0:       sad_tab[k] = (k == 18) ? 7 : 100;
        1:       sad_tab[k] = 32767;
        2:       sad_tab[k] = (k == 2 || k == 12) ? 5 : 100;
        3:       sad_tab[k] = $urandom_range(0, 20);
        default: sad_tab[k] = $urandom_range(0, 32767);
      endcase
    end
  endtask

  function automatic exp_t ref_best();
    exp_t e;
    int   b = 0;
    for (int k = 1; k < 25; k++) begin
      if (sad_tab[k] < sad_tab[b]) b = k;
    end
    e.id = 0;
    e.x  = b % 5 - 2;
    e.y  = 2 - b / 5;
    return e;
  endfunction

  function automatic int rr_pick(input logic [NREQ-1:0] r);
    for (int i = 0; i < NREQ; i++) begin
      if (r[(rr_ptr + i) % NREQ]) return (rr_ptr + i) % NREQ;
    end
    return -1;
  endfunction

  task automatic wait_gnt(input int id);
    int n = 0;
    do begin
      tick();
      n++;
    end while (bus.gnt == '0 && n < 40);
    if (bus.gnt == '0) begin
      chk("gnt_timeout", 0, 1);
      finish_run();
    end
    chk("gnt_id", bus.gnt, 1 << id);
    chk("sel_id", bus.sel_id, id);
    chk("busy_at_gnt", bus.busy, 1);
  endtask

  task automatic run_search(input logic [NREQ-1:0] r, input int mode, input int rmode,
                            input int lat_i, input bit drop);
    exp_t e;
    int   id;
    int   start;
    int   n = 0;
    fill_table(mode);
    ready_mode = rmode;
    lat        = lat_i;
    bus.req    = r;
    id         = rr_pick(r);
    e          = ref_best();
    e.id       = id;
    exp_q.push_back(e);
    start = done_cnt;
    wait_gnt(id);
    if (drop) bus.req = '0;
    while (done_cnt == start && n < 1000) begin
      tick();
      n++;
    end
    if (done_cnt == start) begin
      chk("done_timeout", 0, 1);
      finish_run();
    end
    chk("accepts", scan_k, 25);
    chk("results_before_out", res_sent, 25);
    rr_ptr = (id + 1) % NREQ;
  endtask

  // Engine model: drives cand_ready, records accepts, returns SADs in order after 'lat'.
  always @(negedge clk) begin : engine
    bit          r;
    int          su, sv, k;
    pend_t       p;
    cyc++;
    if (!rst_n) begin
      pend.delete();
      scan_k         = 0;
      res_sent       = 0;
      stalled_prev   = 1'b0;
      prev_busy      = 1'b0;
      prev_gnt       = '0;
      bus.sad_valid  = 1'b0;
      bus.sad_value  = '0;
      bus.cand_ready = 1'b0;
    end else begin
      if (bus.gnt != '0) begin
        chk("gnt_onehot", $countones(bus.gnt), 1);
        chk("gnt_after_idle", prev_busy | (prev_gnt != '0), 0);
        scan_k   = 0;
        res_sent = 0;
      end
      prev_busy = bus.busy;
      prev_gnt  = bus.gnt;

      if (stalled_prev) begin
        chk("stall_valid", bus.cand_valid, 1);
        chk("stall_u", bus.cand_u, held_u);
        chk("stall_v", bus.cand_v, held_v);
      end

      if (pend.size() > 0 && pend[0].due <= cyc) begin
        p             = pend.pop_front();
        bus.sad_valid = 1'b1;
        bus.sad_value = SADW'(p.sad);
        res_sent++;
      end else if (spur_en && (!bus.busy || bus.out_valid)) begin
        bus.sad_valid = 1'b1;
        bus.sad_value = '0;
      end else begin
        bus.sad_valid = 1'b0;
        bus.sad_value = SADW'($urandom);
      end

      case (ready_mode)
        0:       r = 1'b1;
        1:       r = (rphase % 3 == 0);
        default: r = 1'($urandom_range(0, 1));
      endcase
      rphase++;
      bus.cand_ready = r;
      stalled_prev   = bus.cand_valid && !r;
      held_u         = bus.cand_u;
      held_v         = bus.cand_v;

      if (bus.cand_valid && r) begin
        su = $signed(bus.cand_u);
        sv = $signed(bus.cand_v);
        chk("scan_u", su, scan_k % 5 - 2);
        chk("scan_v", sv, 2 - scan_k / 5);
        if (scan_k >= 25) chk("extra_accept", scan_k, 24);
        k     = (2 - sv) * 5 + (su + 2);
        p.due = cyc + lat;
        p.sad = (k >= 0 && k < 25) ? sad_tab[k] : 0;
        pend.push_back(p);
        scan_k++;
      end
    end
  end

  // Monitor: pairs the two out_valid cycles and compares against the scoreboard head.
  always @(negedge clk) begin : monitor
    int   mon_phase;
    int   got_x;
    int   got_id;
    exp_t cur;
    if (!rst_n) begin
      mon_phase = 0;
    end else if (mon_phase == 0) begin
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL out_unexpected: got out_valid=1 expected 0 (t=%0t)", $time);
        end else begin
          got_x     = $signed(bus.out_vector);
          got_id    = bus.out_id;
          mon_phase = 1;
        end
      end
    end else begin
      cur = exp_q.pop_front();
      chk("out_valid_2nd", bus.out_valid, 1);
      chk("out_x", got_x, cur.x);
      chk("out_y", $signed(bus.out_vector), cur.y);
      chk("out_id_x", got_id, cur.id);
      chk("out_id_y", bus.out_id, cur.id);
      done_cnt++;
      mon_phase = 0;
    end
  end

  initial begin
    int n;
    bus.req = '0;
    #1 rst_n = 1'b0;
    #1 check_reset();
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    run_search(4'b0001, 0, 0, 1, 1'b1);
    run_search(4'b0001, 1, 0, 1, 1'b1);
    run_search(4'b0001, 2, 0, 2, 1'b1);
    run_search(4'b0001, 0, 1, 3, 1'b1);

    spur_en = 1'b1;
    repeat (3) tick();
    run_search(4'b0010, 3, 2, 2, 1'b1);
    run_search(4'b0100, 4, 0, 1, 1'b1);
    repeat (3) tick();
    spur_en = 1'b0;

    // Abort a search mid-issue; no result may follow.
    fill_table(4);
    ready_mode = 0;
    lat        = 1;
    bus.req    = 4'b0010;
    wait_gnt(rr_pick(4'b0010));
    bus.req = '0;
    n = 0;
    while (scan_k < 11 && n < 100) begin
      tick();
      n++;
    end
    rst_n = 1'b0;
    #1 check_reset();
    rr_ptr = 0;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (40) tick();

    run_search(4'b1000, 4, 2, 2, 1'b1);

    for (int i = 0; i < 4; i++) run_search(4'b1111, (i % 2 == 0) ? 3 : 4, 2, 1 + i % 3, 1'b0);
    run_search(4'b0101, 4, 0, 1, 1'b0);
    run_search(4'b0101, 3, 1, 2, 1'b0);
    bus.req = '0;
    repeat (10) tick();
    chk("scoreboard_empty", exp_q.size(), 0);
    chk("idle_busy", bus.busy, 0);
    finish_run();
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    failures++;
    finish_run();
  end
endmodule
